// File: rtl/nco_tune_ctrl.sv
// UART command controller owning the carrier NCO phase increment.
// Parses F/U/D/R/? commands, updates phase_inc and replies through uart_tx.
module nco_tune_ctrl #(
  parameter logic [63:0] DEFAULT_INC  = 64'h01B1B1B1B1B1B1B1,
  parameter logic [63:0] STEP_INC     = 64'h00007B5CA45266E2,
  parameter logic [63:0] MAX_INC      = 64'h4000000000000000,
  parameter int unsigned TIMEOUT_CLKS = 1360000
) (
  input  logic        osc_clk,
  input  logic        reset_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic        tx_done,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  output logic [63:0] phase_inc,
  output logic        inc_update,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [7:0] CH_F = 8'h46;
  localparam logic [7:0] CH_U = 8'h55;
  localparam logic [7:0] CH_D = 8'h44;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_Q = 8'h3F;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;

  typedef enum logic [2:0] {IDLE, LOAD, APPLY, SEND, WAIT_TX, DUMP} state_t;

  state_t          state_q, state_d;
  logic [63:0]     inc_q, inc_d;
  logic [63:0]     sreg_q, sreg_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0][7:0] snap_q, snap_d;
  logic [3:0]      idx_q, idx_d;
  logic            dump_q, dump_d;
  logic [7:0]      txb_q, txb_d;

  logic [64:0]     sum_up;
  logic            apply_ok;

  assign sum_up   = {1'b0, inc_q} + {1'b0, STEP_INC};
  assign apply_ok = (state_q == APPLY) && (sreg_q <= MAX_INC);

  // Every increment change funnels through APPLY so U/D/R and F share the
  // same update-then-reply timing; the new value is visible during APPLY.
  assign phase_inc  = apply_ok ? sreg_q : inc_q;
  assign inc_update = apply_ok;
  assign tx_dv      = (state_q == SEND);
  assign tx_byte    = txb_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    inc_d   = inc_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    dump_d  = dump_q;
    txb_d   = txb_q;
    unique case (state_q)
      IDLE: begin
        if (rx_dv) begin
          unique case (rx_byte)
            CH_F: begin
              sreg_d  = '0;
              cnt_d   = '0;
              tmo_d   = '0;
              state_d = LOAD;
            end
            CH_U: begin
              sreg_d  = (sum_up > {1'b0, MAX_INC}) ? MAX_INC : sum_up[63:0];
              state_d = APPLY;
            end
            CH_D: begin
              sreg_d  = (inc_q < STEP_INC) ? '0 : inc_q - STEP_INC;
              state_d = APPLY;
            end
            CH_R: begin
              sreg_d  = DEFAULT_INC;
              state_d = APPLY;
            end
            CH_Q: begin
              snap_d  = inc_q;
              idx_d   = '0;
              dump_d  = 1'b1;
              state_d = DUMP;
            end
            default: begin
              txb_d   = CH_E;
              state_d = SEND;
            end
          endcase
        end
      end
      LOAD: begin
        if (rx_dv) begin
          sreg_d = {sreg_q[55:0], rx_byte};
          cnt_d  = cnt_q + 3'd1;
          tmo_d  = '0;
          if (cnt_q == 3'd7) state_d = APPLY;
        end else if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
          txb_d   = CH_E;
          state_d = SEND;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      APPLY: begin
        if (apply_ok) inc_d = sreg_q;
        txb_d   = apply_ok ? CH_K : CH_E;
        state_d = SEND;
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: begin
        if (tx_done) state_d = dump_q ? DUMP : IDLE;
      end
      DUMP: begin
        if (idx_q[3]) begin
          txb_d  = CH_K;
          dump_d = 1'b0;
        end else begin
          txb_d = snap_q[3'd7 - idx_q[2:0]];
          idx_d = idx_q + 4'd1;
        end
        state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      inc_q   <= DEFAULT_INC;
      sreg_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      snap_q  <= '0;
      idx_q   <= '0;
      dump_q  <= 1'b0;
      txb_q   <= '0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      dump_q  <= dump_d;
      txb_q   <= txb_d;
    end
  end

endmodule
